// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Size codes follow the load/store funct3 width field.
package data_mem_responder_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // One bit per byte lane touched by an access of this size at this offset.
    function automatic logic [7:0] lane_mask(
        input logic [1:0] size,
        input logic [2:0] offset
    );
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0f;
            default: m = 8'hff;
        endcase
        return m << offset;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [2:0] offset
    );
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = offset[0];
            SZ_W:    bad = |offset[1:0];
            default: bad = |offset;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane merge for stores and extract/extend for loads.
// Purely combinational; operands must already be aligned-checked.
module mem_lane_align (
    input  logic [63:0] dword,
    input  logic [63:0] wdata,
    input  logic [1:0]  size,
    input  logic [2:0]  offset,
    input  logic        is_unsigned,
    output logic [63:0] merged,
    output logic [63:0] rdata
);

    import data_mem_responder_pkg::*;

    logic [7:0]  lanes;
    logic [63:0] bit_mask;
    logic [63:0] shifted_w;
    logic [63:0] shifted_r;
    logic [5:0]  shamt;

    assign shamt     = {offset, 3'b000};
    assign lanes     = lane_mask(size, offset);
    assign shifted_w = wdata << shamt;
    assign shifted_r = dword >> shamt;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{lanes[i]}};
        end
    end

    assign merged = (dword & ~bit_mask) | (shifted_w & bit_mask);

    always_comb begin
        rdata = '0;
        case (size)
            SZ_B: begin
                rdata = is_unsigned
                      ? {56'd0, shifted_r[7:0]}
                      : {{56{shifted_r[7]}}, shifted_r[7:0]};
            end
            SZ_H: begin
                rdata = is_unsigned
                      ? {48'd0, shifted_r[15:0]}
                      : {{48{shifted_r[15]}}, shifted_r[15:0]};
            end
            SZ_W: begin
                rdata = is_unsigned
                      ? {32'd0, shifted_r[31:0]}
                      : {{32{shifted_r[31]}}, shifted_r[31:0]};
            end
            default: begin
                rdata = shifted_r;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding request, programmable wait
// states, single-cycle response pulse and pipeline stall.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        stall
);

    import data_mem_responder_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] CNT_INIT =
        (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e      state;
    logic [3:0]  cnt;

    logic        lat_write;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_unsigned;

    logic        cur_write;
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic [1:0]  cur_size;
    logic        cur_unsigned;

    logic [63:0] mem [DEPTH];

    logic          idle;
    logic [AW-1:0] idx;
    logic [2:0]    offset;
    logic          err;
    logic          commit;
    logic [63:0]   merged;
    logic [63:0]   load_data;

    assign idle = (state == IDLE);

    // With zero wait states the access happens on the accept edge,
    // before the latched copy exists, so read the live request then.
    assign cur_write    = idle ? req_write    : lat_write;
    assign cur_addr     = idle ? req_addr     : lat_addr;
    assign cur_wdata    = idle ? req_wdata    : lat_wdata;
    assign cur_size     = idle ? req_size     : lat_size;
    assign cur_unsigned = idle ? req_unsigned : lat_unsigned;

    assign idx    = cur_addr[3 +: AW];
    assign offset = cur_addr[2:0];
    assign err    = misaligned(cur_size, offset)
                  | (|cur_addr[63:3+AW]);

    assign commit = idle ? (req_valid & ZERO_LAT)
                         : ((state == WAIT) & (cnt == 4'd0));

    assign req_ready = idle;
    assign stall     = (idle & req_valid) | (state == WAIT);

    mem_lane_align u_align (
        .dword       (mem[idx]),
        .wdata       (cur_wdata),
        .size        (cur_size),
        .offset      (offset),
        .is_unsigned (cur_unsigned),
        .merged      (merged),
        .rdata       (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= SZ_B;
            lat_unsigned <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_error   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        if (ZERO_LAT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (commit) begin
                resp_valid <= 1'b1;
                resp_error <= err;
                resp_rdata <= (err | cur_write) ? 64'd0 : load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit & cur_write & ~err) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2 main DUT,
// LATENCY=0 second DUT for the zero-wait-state timing).
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_valid1;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;

    logic        req_ready, resp_valid, resp_error, stall;
    logic [63:0] resp_rdata;
    logic        ready1, rv1, re1, stall1;
    logic [63:0] rd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   resp_cyc[$];
    exp_t mon_e;
    logic [7:0] bmem [0:8*DEPTH-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .stall(stall)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(rv1), .resp_rdata(rd1),
        .resp_error(re1), .stall(stall1)
    );

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (resp_rdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL resp_rdata: got %h, required %h", resp_rdata, mon_e.data);
                end
                checks++;
                if (resp_error !== mon_e.err) begin
                    errors++;
                    $display("FAIL resp_error: got %b, required %b", resp_error, mon_e.err);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 8*DEPTH; i++) bmem[i] = 8'h00;
    endtask

    task automatic model_access(
        input logic w, input logic [63:0] a, input logic [63:0] wd,
        input logic [1:0] sz, input logic u, input bit upd,
        output logic [63:0] d, output logic e
    );
        int n;
        n = 1 << sz;
        e = ((a % 64'(n)) != 0) || (a >= 64'(8*DEPTH));
        d = '0;
        if (!e) begin
            if (w) begin
                if (upd) for (int i = 0; i < n; i++) bmem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) d[8*i +: 8] = bmem[int'(a) + i];
                if (!u && n < 8 && d[8*n-1])
                    for (int i = n; i < 8; i++) d[8*i +: 8] = 8'hff;
            end
        end
    endtask

    task automatic issue(
        input logic w, input logic [63:0] a, input logic [63:0] wd,
        input logic [1:0] sz, input logic u,
        input bit use_model, input logic [63:0] xd, input logic xe,
        input bit expect_resp, output int t
    );
        exp_t ex;
        logic [63:0] md;
        logic me;
        bit acc;
        model_access(w, a, wd, sz, u, expect_resp, md, me);
        ex.data = use_model ? md : xd;
        ex.err  = use_model ? me : xe;
        @(posedge clk); #1;
        req_write = w; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = u; req_valid = 1'b1;
        acc = 0;
        t = -1;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1;
                t = cyc;
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_accept: got %b, required 1", stall);
                end
                if (expect_resp) exp_q.push_back(ex);
            end
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout: %0d responses pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 0; req_valid1 = 0; req_write = 0;
        req_addr = '0; req_wdata = '0; req_size = 2'd0; req_unsigned = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, stall, resp_valid, resp_error} !== 4'b1000 || resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/stall/rv/err=%b rdata=%h, required 1000 and 0",
                     {req_ready, stall, resp_valid, resp_error}, resp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, stall, resp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL idle_outputs: rdy/stall/rv=%b, required 100",
                     {req_ready, stall, resp_valid});
        end
    endtask

    task automatic test_load_zero();
        int t;
        resp_cyc.delete();
        issue(0, 64'h0, 64'h0, 2'd3, 0, 0, 64'h0, 0, 1, t);
        wait_drain();
        checks++;
        if (resp_cyc.size() != 1 || resp_cyc[0] != t + LAT + 1) begin
            errors++;
            $display("FAIL load_latency: resp cycles %p, required %0d", resp_cyc, t + LAT + 1);
        end
    endtask

    task automatic test_store_dword();
        int t;
        resp_cyc.delete();
        issue(1, 64'h8, 64'h1122334455667788, 2'd3, 0, 0, 64'h0, 0, 1, t);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (stall !== (k < 3) || resp_valid !== (k == 3)) begin
                errors++;
                $display("FAIL store_stall: T+%0d stall=%b rv=%b, required %b %b",
                         k, stall, resp_valid, k < 3, k == 3);
            end
        end
        wait_drain();
        checks++;
        if (resp_cyc.size() != 1 || resp_cyc[0] != t + LAT + 1) begin
            errors++;
            $display("FAIL store_latency: resp cycles %p, required %0d", resp_cyc, t + LAT + 1);
        end
        issue(0, 64'h8, 64'h0, 2'd3, 0, 0, 64'h1122334455667788, 0, 1, t);
        wait_drain();
    endtask

    task automatic test_byte();
        int t;
        issue(1, 64'h13, 64'hAB, 2'd0, 0, 0, 64'h0, 0, 1, t);
        issue(0, 64'h10, 64'h0, 2'd3, 0, 0, 64'h00000000AB000000, 0, 1, t);
        issue(0, 64'h13, 64'h0, 2'd0, 0, 0, 64'hFFFFFFFFFFFFFFAB, 0, 1, t);
        issue(0, 64'h13, 64'h0, 2'd0, 1, 0, 64'h00000000000000AB, 0, 1, t);
        issue(0, 64'h12, 64'h0, 2'd1, 0, 0, 64'hFFFFFFFFFFFFAB00, 0, 1, t);
        wait_drain();
    endtask

    task automatic test_errors();
        int t;
        issue(0, 64'h6, 64'h0, 2'd2, 0, 0, 64'h0, 1, 1, t);
        issue(1, 64'h6, 64'hDEADBEEFCAFEF00D, 2'd2, 0, 0, 64'h0, 1, 1, t);
        issue(0, 64'h0, 64'h0, 2'd3, 0, 0, 64'h0, 0, 1, t);
        issue(0, 64'h200, 64'h0, 2'd3, 0, 0, 64'h0, 1, 1, t);
        issue(0, 64'h8000000000000008, 64'h0, 2'd3, 0, 0, 64'h0, 1, 1, t);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        bit acc;
        exp_t ex;
        logic [63:0] md;
        logic me;
        resp_cyc.delete();
        @(posedge clk); #1;
        req_write = 1; req_addr = 64'h18; req_wdata = 64'hA5A5A5A55A5A5A5A;
        req_size = 2'd3; req_unsigned = 0; req_valid = 1;
        acc = 0; t1 = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) begin acc = 1; t1 = cyc; end
        end
        model_access(1, 64'h18, 64'hA5A5A5A55A5A5A5A, 2'd3, 0, 1, md, me);
        ex.data = 64'h0; ex.err = 1'b0;
        exp_q.push_back(ex);
        @(posedge clk); #1;
        req_addr = 64'h20; req_wdata = 64'h0123456789ABCDEF;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_low: T+%0d req_ready=%b, required 0", k, req_ready);
            end
        end
        @(negedge clk);
        t2 = cyc;
        checks++;
        if (req_ready !== 1'b1 || t2 != t1 + LAT + 2) begin
            errors++;
            $display("FAIL b2b_second_accept: ready=%b cycle=%0d, required 1 at %0d",
                     req_ready, t2, t1 + LAT + 2);
        end
        model_access(1, 64'h20, 64'h0123456789ABCDEF, 2'd3, 0, 1, md, me);
        exp_q.push_back(ex);
        @(posedge clk); #1;
        req_valid = 0;
        wait_drain();
        checks++;
        if (resp_cyc.size() != 2 || resp_cyc[0] != t1 + LAT + 1
            || resp_cyc[1] != t1 + 2*LAT + 3) begin
            errors++;
            $display("FAIL b2b_resp_cycles: got %p, required %0d and %0d",
                     resp_cyc, t1 + LAT + 1, t1 + 2*LAT + 3);
        end
        issue(0, 64'h18, 64'h0, 2'd3, 0, 1, 64'h0, 0, 1, t1);
        issue(0, 64'h20, 64'h0, 2'd3, 0, 1, 64'h0, 0, 1, t1);
        wait_drain();
    endtask

    task automatic test_zero_latency();
        @(posedge clk); #1;
        req_write = 1; req_addr = 64'h28; req_wdata = 64'h5555AAAA3333CCCC;
        req_size = 2'd3; req_unsigned = 0; req_valid1 = 1;
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1) begin
            errors++;
            $display("FAIL z_accept1: ready=%b, required 1", ready1);
        end
        @(posedge clk); #1;
        req_write = 0;
        @(negedge clk);
        checks++;
        if ({rv1, ready1, re1} !== 3'b100 || rd1 !== 64'd0) begin
            errors++;
            $display("FAIL z_resp1: rv/rdy/err=%b rdata=%h, required 100 and 0",
                     {rv1, ready1, re1}, rd1);
        end
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || rv1 !== 1'b0) begin
            errors++;
            $display("FAIL z_accept2: ready=%b rv=%b, required 1 0", ready1, rv1);
        end
        @(posedge clk); #1;
        req_valid1 = 0;
        @(negedge clk);
        checks++;
        if (rv1 !== 1'b1 || rd1 !== 64'h5555AAAA3333CCCC || re1 !== 1'b0) begin
            errors++;
            $display("FAIL z_resp2: rv=%b rdata=%h err=%b, required 1 5555aaaa3333cccc 0",
                     rv1, rd1, re1);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        issue(1, 64'h10, 64'hFEEDFACE12345678, 2'd3, 0, 0, 64'h0, 0, 0, t);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rv=%b rdy=%b stall=%b, required 0 1 0",
                     resp_valid, req_ready, stall);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle: rv=%b rdy=%b, required 0 1",
                         resp_valid, req_ready);
            end
        end
        issue(0, 64'h10, 64'h0, 2'd3, 0, 0, 64'h0, 0, 1, t);
        issue(0, 64'h8, 64'h0, 2'd3, 0, 0, 64'h0, 0, 1, t);
        wait_drain();
    endtask

    task automatic test_random();
        int t;
        logic [63:0] a;
        logic [1:0] sz;
        for (int k = 0; k < 40; k++) begin
            a = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(9, 63));
            sz = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz,
                  1'($urandom_range(0, 1)), 1, 64'h0, 0, 1, t);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_load_zero();
        test_store_dword();
        test_byte();
        test_errors();
        test_back_to_back();
        test_zero_latency();
        test_reset_mid();
        test_random();
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
